// File: rtl/id_ex_elastic_stage.sv
// id_ex_elastic_stage: ID/EX valid/ready stage with two-entry skid buffer, flush and saturating stall counter
module id_ex_elastic_stage #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 123,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Flush,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [CTRL_W-1:0] In_Ctrl,
   input  logic [DATA_W-1:0] In_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [CTRL_W-1:0] Out_Ctrl,
   output logic [DATA_W-1:0] Out_Data,
   output logic [CNT_W-1:0]  Stall_Cnt
);
   logic              main_v, skid_v, in_rdy;
   logic [CTRL_W-1:0] main_c, skid_c;
   logic [DATA_W-1:0] main_d, skid_d;
   logic [CNT_W-1:0]  cnt;
   logic              accept, pop, load_main, load_skid, shift, main_v_n, skid_v_n;
   always_comb begin
      accept    = In_Valid & in_rdy;
      pop       = main_v & Out_Ready;
      load_main = ~Flush & accept & (~main_v | pop);
      load_skid = ~Flush & accept & main_v & ~pop;
      shift     = ~Flush & skid_v & pop;
      main_v_n  = ~Flush & (load_main | skid_v | (main_v & ~pop));
      skid_v_n  = ~Flush & (load_skid | (skid_v & ~pop));
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         in_rdy <= 1'b1;
         main_c <= '0;
         main_d <= '0;
         skid_c <= '0;
         skid_d <= '0;
         cnt    <= '0;
      end else begin
         main_v <= main_v_n;
         skid_v <= skid_v_n;
         in_rdy <= ~skid_v_n;
         main_c <= shift ? skid_c : load_main ? In_Ctrl : main_c;
         main_d <= shift ? skid_d : load_main ? In_Data : main_d;
         skid_c <= load_skid ? In_Ctrl : skid_c;
         skid_d <= load_skid ? In_Data : skid_d;
         cnt    <= (main_v & ~Out_Ready & ~&cnt) ? cnt + 1'b1 : cnt;
      end
   end
   assign In_Ready  = in_rdy;
   assign Out_Valid = main_v;
   assign Out_Ctrl  = main_c & {CTRL_W{main_v}};
   assign Out_Data  = main_d;
   assign Stall_Cnt = cnt;
endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// tb_id_ex_elastic_stage: directed scoreboard bench for id_ex_elastic_stage
module tb_id_ex_elastic_stage;
   localparam int CW = 8;
   localparam int DW = 16;
   localparam int NW = 4;
   logic          Clk = 1'b0, Rst = 1'b1, Flush = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b0;
   logic [CW-1:0] In_Ctrl = '0;
   logic [DW-1:0] In_Data = '0;
   logic          In_Ready, Out_Valid;
   logic [CW-1:0] Out_Ctrl;
   logic [DW-1:0] Out_Data;
   logic [NW-1:0] Stall_Cnt;
   logic [23:0]   q[$];
   int            tests = 0, fails = 0;
   logic [NW-1:0] exp_cnt = '0;
   id_ex_elastic_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
      .Clk(Clk), .Rst(Rst), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data), .Stall_Cnt(Stall_Cnt));
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // One clock: compare pops before the edge, record accepts at the edge, check holds after it.
   task automatic tick();
      logic          acc, hold;
      logic [23:0]   e;
      logic [DW-1:0] hd;
      logic [CW-1:0] hc;
      acc = In_Valid & In_Ready;
      if (!Out_Valid) chk("bubble_ctrl", 32'(Out_Ctrl), 32'd0);
      if (Out_Valid && Out_Ready) begin
         if (q.size() == 0) chk("spurious_pop", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("out_data", 32'(Out_Data), 32'(e[15:0]));
            chk("out_ctrl", 32'(Out_Ctrl), 32'(e[23:16]));
         end
      end
      hold = Out_Valid & !Out_Ready & !Flush & !Rst;
      hd = Out_Data;
      hc = Out_Ctrl;
      if (Rst) exp_cnt = '0;
      else if (Out_Valid && !Out_Ready && exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;
      @(posedge Clk);
      if (Rst || Flush) q.delete();
      else if (acc) q.push_back({In_Ctrl, In_Data});
      @(negedge Clk);
      if (hold) begin
         chk("hold_valid", 32'(Out_Valid), 32'd1);
         chk("hold_data", 32'(Out_Data), 32'(hd));
         chk("hold_ctrl", 32'(Out_Ctrl), 32'(hc));
      end
      chk("stall_cnt", 32'(Stall_Cnt), 32'(exp_cnt));
   endtask
   task automatic drive(input logic v, input int d);
      In_Valid = v;
      In_Data  = DW'(d);
      In_Ctrl  = CW'(d * 7 + 1);
   endtask
   initial begin
      @(negedge Clk);
      tick();
      tick();
      Rst = 1'b0;
      chk("rst_valid", 32'(Out_Valid), 32'd0);
      chk("rst_ctrl", 32'(Out_Ctrl), 32'd0);
      chk("rst_data", 32'(Out_Data), 32'd0);
      chk("rst_ready", 32'(In_Ready), 32'd1);
      Out_Ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, i);
         tick();
         chk("stream_valid", 32'(Out_Valid), 32'd1);
         chk("stream_ready", 32'(In_Ready), 32'd1);
      end
      drive(1'b0, 0);
      tick();
      chk("stream_drained", 32'(q.size()), 32'd0);
      chk("stream_cnt", 32'(Stall_Cnt), 32'd0);
      drive(1'b1, 9);
      tick();
      Out_Ready = 1'b0;
      drive(1'b1, 10);
      tick();
      chk("bp_ready_low", 32'(In_Ready), 32'd0);
      drive(1'b1, 11);
      tick();
      tick();
      chk("bp_ready_low2", 32'(In_Ready), 32'd0);
      chk("bp_cnt", 32'(Stall_Cnt), 32'd3);
      chk("bp_held", 32'(q.size()), 32'd2);
      Out_Ready = 1'b1;
      drive(1'b0, 0);
      tick();
      chk("bp_no_gap", 32'(Out_Valid), 32'd1);
      tick();
      chk("bp_drained", 32'(q.size()), 32'd0);
      chk("bp_empty", 32'(Out_Valid), 32'd0);
      Out_Ready = 1'b0;
      drive(1'b1, 20);
      tick();
      drive(1'b1, 21);
      tick();
      chk("skid_full", 32'(In_Ready), 32'd0);
      drive(1'b0, 0);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      chk("flush_valid", 32'(Out_Valid), 32'd0);
      chk("flush_ctrl", 32'(Out_Ctrl), 32'd0);
      chk("flush_ready", 32'(In_Ready), 32'd1);
      Out_Ready = 1'b1;
      drive(1'b1, 22);
      tick();
      chk("post_flush_valid", 32'(Out_Valid), 32'd1);
      chk("post_flush_data", 32'(Out_Data), 32'd22);
      drive(1'b0, 0);
      tick();
      Out_Ready = 1'b0;
      drive(1'b1, 30);
      tick();
      drive(1'b1, 31);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      drive(1'b0, 0);
      chk("flush_acc_valid", 32'(Out_Valid), 32'd0);
      chk("flush_acc_ready", 32'(In_Ready), 32'd1);
      Out_Ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_acc_gone", 32'(Out_Valid), 32'd0);
      end
      In_Ctrl = '1;
      In_Valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mask_ctrl", 32'(Out_Ctrl), 32'd0);
      end
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      Out_Ready = 1'b0;
      drive(1'b1, 40);
      tick();
      drive(1'b0, 0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cnt", 32'(Stall_Cnt), 32'd15);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      chk("sat_rst_cnt", 32'(Stall_Cnt), 32'd0);
      chk("sat_rst_valid", 32'(Out_Valid), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/id_ex_elastic_stage.md
# id_ex_elastic_stage

Parametrised elastic pipeline stage between decode and execute that carries a control bundle and a data bundle. It replaces the fixed-width free-running ID/EX latch. It adds a valid/ready handshake, a two-entry skid buffer so back-pressure never drops an instruction, a synchronous flush for branch and exception squash, and a saturating stall counter for performance monitoring. Outgoing control is forced to zero whenever the stage holds no valid instruction, so a bubble can never write a register or memory.

## Interface
Parameters:
- CTRL_W, default 8: width of the control bundle (WB, MEM and EX fields concatenated by the decoder).
- DATA_W, default 123: width of the data bundle (register specifiers, shamt, funct, RD1, RD2, extended immediate).
- CNT_W, default 16: width of the stall counter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Flush  input  1  squash all held entries; takes priority over every handshake.
- In_Valid  input  1  decode presents an instruction.
- In_Ready  output  1  stage can accept; registered.
- In_Ctrl  input  CTRL_W  control bundle from decode.
- In_Data  input  DATA_W  data bundle from decode.
- Out_Valid  output  1  stage presents an instruction to execute.
- Out_Ready  input  1  execute consumes this cycle.
- Out_Ctrl  output  CTRL_W  control bundle to execute; all-zero when Out_Valid=0.
- Out_Data  output  DATA_W  data bundle to execute; don't-care when Out_Valid=0 but must be stable.
- Stall_Cnt  output  CNT_W  number of cycles with Out_Valid=1 and Out_Ready=0, saturating.

## Operation
- Storage is a main entry (drives the outputs) and a skid entry. Each entry holds a valid bit, control and data.
- Accept = In_Valid & In_Ready. Pop = Out_Valid & Out_Ready.
- States, encoded by the valid bits:
  - EMPTY: no entries valid.
  - FULL: main valid.
  - SKID: main and skid valid.
- Transitions when Flush=0:
  - EMPTY, accept: load main, go to FULL.
  - FULL, accept with no pop: load skid, go to SKID.
  - FULL, accept with pop: reload main from input, stay FULL.
  - FULL, pop with no accept: go to EMPTY.
  - SKID, pop: move skid into main, go to FULL. Accept cannot occur because In_Ready=0.
  - Otherwise: hold all state.
- In_Ready next value = 1 in EMPTY and FULL, 0 in SKID. It is computed from the next state.
- Flush=1, regardless of state, Accept or Pop:
  - Both valid bits clear next edge; state becomes EMPTY; In_Ready becomes 1.
  - An input accepted in the flush cycle is discarded.
  - A pop in the flush cycle counts as consumed by execute.
  - Data registers need not clear.
- Out_Ctrl = main control AND-masked with main valid.
- Stall_Cnt increments by 1 on each edge where Out_Valid=1 and Out_Ready=0. It saturates at 2^CNT_W-1. Flush does not clear it; Rst does.
- Priority: Rst > Flush > handshake.

## Timing
- Reset values:
  - Out_Valid=0, Out_Ctrl=0, Out_Data=0, Stall_Cnt=0.
  - In_Ready=1, both valid bits 0.
- Latency: an input accepted at edge N appears on Out_* after edge N (one cycle) when the stage was EMPTY, or when it was FULL and popped.
- Throughput: one instruction per cycle sustained while Out_Ready=1.
- Under back-pressure, at most one further instruction is absorbed (into the skid entry) after Out_Ready drops. No instruction is lost or duplicated.
- In_Ready depends only on registers; there is no combinational path from Out_Ready to In_Ready.
- Reset in mid-operation discards both entries at the next edge, identical to flush, and additionally clears Stall_Cnt.
- Out_Data and Out_Ctrl must not change while Out_Valid=1 and Out_Ready=0.

## Test plan
- Reset then stream: Rst for 2 cycles, then In_Valid=1 with Out_Ready=1 for 8 cycles, Data=1..8. Required: Out_Valid rises one cycle after the first accept; Out_Data=1..8 in order, one per cycle; In_Ready stays 1; Stall_Cnt=0.
- Back-pressure: while streaming, drop Out_Ready for 3 cycles. Required:
  - Out_Data holds its value.
  - Exactly one extra item is captured, and In_Ready=0 after that.
  - When Out_Ready returns, items drain in order with no gap or duplicate.
  - Stall_Cnt=3.
- Flush in SKID state: fill both entries (Out_Ready=0), then assert Flush for 1 cycle. Required: next cycle Out_Valid=0, Out_Ctrl=0, In_Ready=1; the following accept emerges after one cycle.
- Flush with simultaneous accept: In_Valid=1 and Flush=1 in the same cycle from FULL. Required: the accepted item never appears at the output; the stage is EMPTY.
- Bubble control masking: In_Ctrl=all-ones with In_Valid=0. Required: Out_Ctrl stays 0 throughout.
- Counter saturation: with CNT_W=4, hold Out_Ready=0 with a valid item for 20 cycles. Required: Stall_Cnt stops at 15; Rst returns it to 0.
